// File: rtl/clk_div_monitor.sv
// clk_div_monitor: samples a slow divided clock in the clk domain, emits
// rise/fall enable strobes, measures period/high time, reports lock/stall.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   rst          synchronous reset, active-high
//   sclk_in      divided clock to monitor (may be asynchronous)
//   rise_tick    one-cycle strobe per sclk_in rising edge
//   fall_tick    one-cycle strobe per sclk_in falling edge
//   period       clk cycles between the last two rise_ticks
//   period_valid one-cycle strobe when period updates
//   high_time    clk cycles from last rise_tick to following fall_tick
//   locked       period stable for LOCK_COUNT consecutive comparisons
//   stalled      no rising edge within TIMEOUT cycles
module clk_div_monitor #(
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 2000000,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk_in,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [CNT_W-1:0] high_time,
    output logic             locked,
    output logic             stalled
);

    localparam int MW = $clog2(LOCK_COUNT + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   TOLV    = (CNT_W+1)'(TOL);
    localparam logic [MW-1:0]    LOCK_N  = MW'(LOCK_COUNT);
    localparam logic [MW-1:0]    M_ONE   = MW'(1);

    logic             s1, s2, s3;
    logic [1:0]       guard;
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [MW-1:0]    match_cnt;
    logic             primed;

    logic             rise_det;
    logic             fall_det;
    logic [CNT_W:0]   diff;
    logic             in_tol;
    logic [MW-1:0]    match_inc;

    // Detection is masked while guard counts down after reset so that an
    // sclk_in already high at reset does not look like a rising edge.
    assign rise_det = s2 & ~s3 & (guard == 2'd0);
    assign fall_det = ~s2 & s3 & (guard == 2'd0);

    // cnt holds the period being closed; compare against the previous one.
    always_comb begin
        diff = '0;
        if ({1'b0, cnt} >= {1'b0, period})
            diff = {1'b0, cnt} - {1'b0, period};
        else
            diff = {1'b0, period} - {1'b0, cnt};
    end

    assign in_tol    = (diff <= TOLV);
    assign match_inc = (match_cnt == LOCK_N) ? match_cnt
                                             : match_cnt + M_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            guard        <= 2'd3;
            state        <= IDLE;
            cnt          <= '0;
            hcnt         <= '0;
            match_cnt    <= '0;
            primed       <= 1'b0;
            rise_tick    <= 1'b0;
            fall_tick    <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            high_time    <= '0;
            locked       <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            s1 <= sclk_in;
            s2 <= s1;
            s3 <= s2;

            if (guard != 2'd0)
                guard <= guard - 2'd1;

            rise_tick    <= rise_det;
            fall_tick    <= fall_det;
            period_valid <= 1'b0;

            if (rise_det)
                hcnt <= ONE;
            else if (hcnt != CNT_MAX)
                hcnt <= hcnt + ONE;

            // A fall before the first reference rise has no rise to measure from.
            if (fall_det && state == RUN)
                high_time <= hcnt;

            if (rise_det) begin
                stalled <= 1'b0;
                cnt     <= ONE;
                if (state == IDLE) begin
                    state  <= RUN;
                    primed <= 1'b0;
                end else begin
                    period       <= cnt;
                    period_valid <= 1'b1;
                    primed       <= 1'b1;
                    // The first period after entering RUN has nothing to
                    // compare against.
                    if (primed) begin
                        if (in_tol) begin
                            match_cnt <= match_inc;
                            locked    <= (match_inc == LOCK_N);
                        end else begin
                            match_cnt <= '0;
                            locked    <= 1'b0;
                        end
                    end
                end
            end else if (cnt == TMO) begin
                stalled   <= 1'b1;
                locked    <= 1'b0;
                match_cnt <= '0;
                state     <= IDLE;
                cnt       <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
Receiving end of the divided-clock path. Samples a slow divided clock (sclk_in, e.g. the divider's sclk) in the fast clk domain and emits single-cycle rise/fall strobes for use as clock enables. Measures the period and high time in clk cycles, reports lock once the period is stable, and flags a stalled divider. Sits beside the clock divider in the OTTER wrapper and feeds enable-driven peripherals and a debug/status register.

Parameters:
CNT_W, 32, width of period/high_time/internal counter
TIMEOUT, 2000000, clk cycles without a rising edge before stalled asserts (must be < 2^CNT_W - 1)
LOCK_COUNT, 4, consecutive in-tolerance period comparisons required for locked
TOL, 0, max allowed |period_new - period_prev| counted as a match

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
sclk_in  in  1  divided clock to monitor; may be asynchronous
rise_tick  out  1  one-cycle strobe per sclk_in rising edge
fall_tick  out  1  one-cycle strobe per sclk_in falling edge
period  out  CNT_W  clk cycles between the last two rise_ticks
period_valid  out  1  one-cycle strobe when period updates
high_time  out  CNT_W  clk cycles from last rise_tick to following fall_tick
locked  out  1  period stable
stalled  out  1  no rising edge within TIMEOUT cycles

Behaviour:
- One clock (clk); reset is synchronous and active-high on rst.
- Reset: all outputs 0; sync chain s1/s2/s3 = 0; state IDLE; cnt = 0; hcnt = 0; match_cnt = 0; guard = 3.
- Synchroniser: s1<=sclk_in, s2<=s1, s3<=s2.
- Edge detect (registered): rise_tick <= s2 & ~s3; fall_tick <= ~s2 & s3.
- Latency: sclk_in first sampled high at edge n means rise_tick is high from edge n+2 to n+3. Same latency applies to fall_tick.
- Guard: for 3 cycles after rst deasserts, the guard counter is non-zero. During that window rise/fall detection is forced to 0 and counters still run. This suppresses a spurious edge when sclk_in is high at reset.
- rise_tick and fall_tick are never high in the same cycle.
- FSM states: IDLE (no reference rise yet) and RUN.
- IDLE:
  - cnt increments, saturating at all-ones.
  - On a detected rise: go to RUN, cnt<=1, hcnt<=1, stalled<=0. No period update.
- RUN:
  - Every cycle without a detected rise: cnt<=cnt+1.
  - On a detected rise: period<=cnt; period_valid<=1 (same cycle as rise_tick); cnt<=1.
  - Result: ticks at cycles t and t+P give period=P. The minimum measurable period is 2.
- high_time:
  - hcnt<=1 on rise, otherwise increments (saturating).
  - On a detected fall in RUN: high_time<=hcnt.
  - A fall in IDLE is ignored.
- Lock:
  - On each period update after the first in RUN, compare the new period with the previous one.
  - If the difference is <= TOL: match_cnt increments, saturating at LOCK_COUNT. Otherwise match_cnt<=0.
  - locked = (match_cnt == LOCK_COUNT), registered with the period update. A mismatch clears locked on that update.
  - The first period after entering RUN is never compared.
- Stall:
  - If cnt reaches TIMEOUT in any state with no rise that cycle: stalled<=1, locked<=0, match_cnt<=0, state<=IDLE, cnt<=0.
  - stalled then holds until the next detected rise.
  - A rise coincident with cnt==TIMEOUT wins: no stall.
- Reset mid-operation restores all reset values on the next edge. Outputs are not held across reset.
- Arithmetic is unsigned. The |difference| is computed at CNT_W+1 bits to avoid wrap.

Test Plan:
1. Drive sclk_in toggling every clk (divider MAX_COUNT=0) -> rise_tick every 2 cycles; period=2 and high_time=1 from the 2nd rise on; locked=1 at the 6th rise (LOCK_COUNT=4).
2. sclk_in divided with MAX_COUNT=9 (high 10, low 10) -> period=20, high_time=10, period_valid coincident with rise_tick, locked after 5 periods; sclk_in 0→1 at edge n gives rise_tick high at edge n+2 exactly.
3. Locked at period 20, then one period of 22 (TOL=0) -> locked drops on that period_valid; four further periods of 22 -> locked re-asserts on the 4th.
4. TIMEOUT=50, sclk_in held low after lock -> stalled=1 and locked=0 exactly 50 cycles after the last rise_tick; next rise clears stalled and gives no period_valid; the following rise gives a valid period.
5. sclk_in=1 while rst is high, release rst -> no rise_tick during the 3 guard cycles; the first rise_tick comes only after a real 0→1 transition.
6. Assert rst for 1 cycle mid-RUN while locked -> next cycle all outputs 0 and state IDLE; measurement resumes after two rises.
